// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the core's instruction memory.
// Receives a framed byte stream from the host link, packs the bytes into
// little-endian 32-bit words, and writes each word to instruction memory.
// When the XOR checksum matches, it releases the core's reset.
// Frame format: LEN_LO, LEN_HI, 4*N data bytes, CHK.
// CHK is the XOR of every preceding frame byte.
//
// Ports:
//   clk, rst      clock (rising edge) / asynchronous active-high reset
//   start         one-cycle pulse; re-arms the loader from DONE or ERROR
//   in_valid      host byte valid
//   in_data       host byte
//   in_ready      loader can accept a byte
//   imem_we       one-cycle write strobe
//   imem_addr     word address of the write
//   imem_wdata    word being written
//   cpu_rst       core reset; low only in DONE
//   done          load finished with a good checksum
//   error         load failed (length overflow or bad checksum)
//   words_loaded  number of words written in the current load
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_LO, S_LEN_HI, S_DATA, S_CHK, S_DONE, S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  state_t          state, stateNxt;
  logic [15:0]     lenWords;
  logic [1:0]      byteIdx;
  logic [7:0]      xorAcc;
  logic [23:0]     wordLo;   // lower three bytes of the word being assembled
  logic [ADDR_W:0] wordsCnt;

  logic        xfer;
  logic [15:0] lenFull;
  logic        lastWord;
  logic        rearm;

  assign in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                    (state == S_DATA)   || (state == S_CHK);
  assign xfer     = in_valid && in_ready;
  assign lenFull  = {in_data, lenWords[7:0]};
  // The word being completed now is the final word of the frame.
  assign lastWord = (17'(wordsCnt) + 17'd1) == {1'b0, lenWords};
  assign rearm    = start && ((state == S_DONE) || (state == S_ERROR));

  assign done         = (state == S_DONE);
  assign error        = (state == S_ERROR);
  // When start arrives in DONE, cpu_rst goes high in that same cycle,
  // before the state register has left DONE.
  assign cpu_rst      = (state != S_DONE) || start;
  assign words_loaded = wordsCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LEN_LO;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      S_LEN_LO: if (xfer) stateNxt = S_LEN_HI;
      S_LEN_HI: if (xfer) begin
        if ({1'b0, lenFull} > DEPTH) stateNxt = S_ERROR;
        else if (lenFull == 16'd0)   stateNxt = S_CHK;
        else                         stateNxt = S_DATA;
      end
      S_DATA:   if (xfer && byteIdx == 2'd3 && lastWord) stateNxt = S_CHK;
      S_CHK:    if (xfer) stateNxt = (in_data == xorAcc) ? S_DONE : S_ERROR;
      S_DONE,
      S_ERROR:  if (start) stateNxt = S_LEN_LO;
      default:  stateNxt = S_LEN_LO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lenWords   <= '0;
      byteIdx    <= '0;
      xorAcc     <= '0;
      wordLo     <= '0;
      wordsCnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      if (rearm) begin
        lenWords <= '0;
        byteIdx  <= '0;
        xorAcc   <= '0;
        wordsCnt <= '0;
      end else if (xfer) begin
        case (state)
          S_LEN_LO: begin
            lenWords[7:0] <= in_data;
            xorAcc        <= xorAcc ^ in_data;
          end
          S_LEN_HI: begin
            lenWords[15:8] <= in_data;
            xorAcc         <= xorAcc ^ in_data;
          end
          S_DATA: begin
            xorAcc  <= xorAcc ^ in_data;
            byteIdx <= byteIdx + 2'd1;
            case (byteIdx)
              2'd0: wordLo[7:0]   <= in_data;
              2'd1: wordLo[15:8]  <= in_data;
              2'd2: wordLo[23:16] <= in_data;
              default: begin
                // The fourth byte goes straight into the write. The strobe
                // and the count update appear together on the next cycle.
                imem_we    <= 1'b1;
                imem_wdata <= {in_data, wordLo};
                imem_addr  <= wordsCnt[ADDR_W-1:0];
                wordsCnt   <= wordsCnt + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Write log. Only the monitor writes it; each test records a base index.
  int          logCnt = 0;
  logic [7:0]  logAddr [0:511];
  logic [31:0] logData [0:511];
  always @(negedge clk) begin
    if (!rst && imem_we && logCnt < 512) begin
      logAddr[logCnt] <= imem_addr;
      logData[logCnt] <= imem_wdata;
      logCnt <= logCnt + 1;
    end
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic        rdy, dn, er, cr;
    logic [8:0]  wl;
  } vec_t;

  vec_t tbl [13];
  byte unsigned frameQ [$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic we, logic [7:0] addr,
                              logic [31:0] wd, logic rdy, logic dn, logic er,
                              logic cr, logic [8:0] wl);
    vec_t r;
    r.v = v; r.d = d; r.we = we; r.addr = addr; r.wd = wd;
    r.rdy = rdy; r.dn = dn; r.er = er; r.cr = cr; r.wl = wl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({imem_we, imem_addr, imem_wdata, in_ready, done, error, cpu_rst, words_loaded});
  endfunction

  task automatic doStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Sends frameQ. gapPct > 0 inserts random idle cycles before bytes.
  task automatic sendFrame(input int gapPct);
    int t;
    int g;
    foreach (frameQ[i]) begin
      g = 0;
      while (gapPct > 0 && g < 8 && $urandom_range(0, 99) < gapPct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        g++;
      end
      in_valid = 1'b1;
      in_data  = frameQ[i];
      t = 0;
      while (!in_ready && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 100) begin
        total++; bad++;
        $display("FAIL handshake_timeout: byte %0d in_ready stuck at 0, expected 1", i);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic loadBasic(input logic [7:0] chkByte);
    frameQ = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
               8'hEF, 8'hBE, 8'hAD, 8'hDE};
    frameQ.push_back(chkByte);
  endtask

  initial begin
    int base;
    int errs;
    logic [31:0] w;
    logic [7:0]  x;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #3;
    chk("reset_values", outs(), 64'({1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 9'd0}));
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // Basic load at full rate. Each row holds the outputs after its edge.
    tbl[0]  = mk(1, 8'h02, 0, 8'd0, 32'h0,        1, 0, 0, 1, 9'd0);
    tbl[1]  = mk(1, 8'h00, 0, 8'd0, 32'h0,        1, 0, 0, 1, 9'd0);
    tbl[2]  = mk(1, 8'h78, 0, 8'd0, 32'h0,        1, 0, 0, 1, 9'd0);
    tbl[3]  = mk(1, 8'h56, 0, 8'd0, 32'h0,        1, 0, 0, 1, 9'd0);
    tbl[4]  = mk(1, 8'h34, 0, 8'd0, 32'h0,        1, 0, 0, 1, 9'd0);
    tbl[5]  = mk(1, 8'h12, 1, 8'd0, 32'h12345678, 1, 0, 0, 1, 9'd1);
    tbl[6]  = mk(1, 8'hEF, 0, 8'd0, 32'h12345678, 1, 0, 0, 1, 9'd1);
    tbl[7]  = mk(1, 8'hBE, 0, 8'd0, 32'h12345678, 1, 0, 0, 1, 9'd1);
    tbl[8]  = mk(1, 8'hAD, 0, 8'd0, 32'h12345678, 1, 0, 0, 1, 9'd1);
    tbl[9]  = mk(1, 8'hDE, 1, 8'd1, 32'hDEADBEEF, 1, 0, 0, 1, 9'd2);
    tbl[10] = mk(1, 8'h28, 0, 8'd1, 32'hDEADBEEF, 0, 1, 0, 0, 9'd2);
    tbl[11] = mk(1, 8'h55, 0, 8'd1, 32'hDEADBEEF, 0, 1, 0, 0, 9'd2);
    tbl[12] = mk(0, 8'h00, 0, 8'd1, 32'hDEADBEEF, 0, 1, 0, 0, 9'd2);
    for (int i = 0; i < 13; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      @(posedge clk); #1;
      chk($sformatf("basic_row%0d", i), outs(),
          64'({tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].rdy, tbl[i].dn,
               tbl[i].er, tbl[i].cr, tbl[i].wl}));
    end
    in_valid = 1'b0;

    // Re-arm. cpu_rst rises during the start cycle, and a byte offered
    // alongside start is not consumed.
    start = 1'b1; in_valid = 1'b1; in_data = 8'h11;
    #1;
    chk("start_same_cycle", 64'({cpu_rst, in_ready, done}), 64'(3'b101));
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    chk("rearm_state", 64'({in_ready, done, error, cpu_rst, words_loaded}),
        64'({1'b1, 1'b0, 1'b0, 1'b1, 9'd0}));
    base = logCnt;
    frameQ = '{8'h01, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hC8};
    sendFrame(0);
    chk("one_word_writes", 64'(logCnt - base), 64'd1);
    chk("one_word_data", 64'({logAddr[base], logData[base]}), 64'({8'd0, 32'hCAFEF00D}));
    chk("one_word_final", 64'({done, error, cpu_rst, words_loaded}),
        64'({1'b1, 1'b0, 1'b0, 9'd1}));

    // Bad checksum: both writes still happen, and the loader ends in ERROR.
    doStart();
    base = logCnt;
    loadBasic(8'hD7);
    sendFrame(0);
    chk("badchk_writes", 64'(logCnt - base), 64'd2);
    chk("badchk_data", {logData[base], logData[base+1]}, {32'h12345678, 32'hDEADBEEF});
    chk("badchk_final", 64'({in_ready, done, error, cpu_rst, words_loaded}),
        64'({1'b0, 1'b0, 1'b1, 1'b1, 9'd2}));

    // Length overflow: N = 257.
    doStart();
    base = logCnt;
    frameQ = '{8'h01, 8'h01};
    sendFrame(0);
    chk("overflow_final", 64'({in_ready, done, error, cpu_rst}), 64'(4'b0011));
    repeat (3) @(posedge clk);
    #1;
    chk("overflow_nowrites", 64'(logCnt - base), 64'd0);

    // Zero length.
    doStart();
    base = logCnt;
    frameQ = '{8'h00, 8'h00, 8'h00};
    sendFrame(0);
    chk("zero_len_final", 64'({done, error, cpu_rst, words_loaded}),
        64'({1'b1, 1'b0, 1'b0, 9'd0}));
    chk("zero_len_nowrites", 64'(logCnt - base), 64'd0);

    // Gapped handshake.
    doStart();
    base = logCnt;
    loadBasic(8'h28);
    sendFrame(50);
    chk("gapped_writes", 64'(logCnt - base), 64'd2);
    chk("gapped_log", 64'({logAddr[base], logData[base]}), 64'({8'd0, 32'h12345678}));
    chk("gapped_log2", 64'({logAddr[base+1], logData[base+1]}), 64'({8'd1, 32'hDEADBEEF}));
    chk("gapped_final", 64'({done, error, cpu_rst, words_loaded}),
        64'({1'b1, 1'b0, 1'b0, 9'd2}));

    // Full depth: N = 256. Word k = {~k, k, 5A, k}.
    doStart();
    base = logCnt;
    frameQ = '{8'h00, 8'h01};
    x = 8'h01;
    for (int k = 0; k < 256; k++) begin
      w = {~k[7:0], k[7:0], 8'h5A, k[7:0]};
      for (int b = 0; b < 4; b++) begin
        frameQ.push_back(w[b*8 +: 8]);
        x = x ^ w[b*8 +: 8];
      end
    end
    frameQ.push_back(x);
    sendFrame(0);
    chk("full_writes", 64'(logCnt - base), 64'd256);
    errs = 0;
    for (int k = 0; k < 256; k++) begin
      w = {~k[7:0], k[7:0], 8'h5A, k[7:0]};
      if (logAddr[base+k] !== k[7:0] || logData[base+k] !== w) errs++;
    end
    chk("full_log", 64'(errs), 64'd0);
    chk("full_last", 64'({logAddr[base+255], logData[base+255]}), 64'({8'hFF, 32'h00FF5AFF}));
    chk("full_final", 64'({done, error, cpu_rst, words_loaded}),
        64'({1'b1, 1'b0, 1'b0, 9'd256}));

    // Reset mid-DATA: the outputs clear without waiting for a clock edge.
    doStart();
    frameQ = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    sendFrame(0);
    base = logCnt;
    #2 rst = 1'b1;
    #1;
    chk("async_reset", outs(), 64'({1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 9'd0}));
    in_valid = 1'b1; in_data = 8'hCC;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("reset_nowrites", 64'(logCnt - base), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    frameQ = '{8'h00, 8'h00, 8'h00};
    sendFrame(0);
    chk("after_reset_armed", 64'({done, error, cpu_rst, words_loaded}),
        64'({1'b1, 1'b0, 1'b0, 9'd0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the pipelined core's instruction memory.
- The fetch unit only reads instruction memory; this block fills it from a byte-stream host link (UART/debug bridge) before the core runs.
- Accepts a framed byte stream on a valid/ready handshake, packs bytes into 32-bit words, issues word writes, verifies a checksum, then releases the core's reset.

Parameters:
- ADDR_W, 8, word-address width of instruction memory; depth = 2**ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; re-arms loader from DONE or ERROR.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader can accept byte; transfer when in_valid && in_ready.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_W  word address for write.
- imem_wdata  output  32  word to write.
- cpu_rst  output  1  active-high reset to core; high except in DONE.
- done  output  1  load completed with good checksum.
- error  output  1  load failed (bad length or checksum).
- words_loaded  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Frame format: LEN_LO, LEN_HI (N = 16-bit word count, little-endian), 4*N data bytes, CHK. Each word is little-endian: first byte goes to bits [7:0], fourth byte to bits [31:24]. CHK = XOR of all preceding frame bytes, including the length bytes.
- States: LEN_LO, LEN_HI, DATA, CHK, DONE, ERROR.
- Reset (asynchronous) values:
  - state = LEN_LO (armed immediately after reset);
  - in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0;
  - cpu_rst=1, done=0, error=0, words_loaded=0;
  - internal byte index=0, running XOR=0, N=0.
- in_ready = 1 in LEN_LO, LEN_HI, DATA and CHK; 0 in DONE and ERROR. A byte is consumed only on an accepted transfer; in_valid low stalls without side effects.
- LEN_LO: accept byte -> N[7:0], fold into XOR -> LEN_HI.
- LEN_HI: accept byte -> N[15:8], fold into XOR, then:
  - N > 2**ADDR_W -> ERROR;
  - N == 0 -> CHK;
  - otherwise -> DATA.
- DATA: each accepted byte is placed in the byte-index lane of a word shift register and folded into XOR; byte index wraps 3->0. When the 4th byte is accepted:
  - next cycle: imem_we=1 for exactly one cycle, imem_wdata = assembled word, imem_addr = words_loaded (pre-increment value);
  - words_loaded increments in that same cycle.
- Write latency: 1 cycle after the 4th byte handshake. Back-to-back bytes at full rate are supported, with no stall between words.
- DATA exit: when the word count reaches N, the state moves to CHK together with the final write strobe.
- CHK: accept byte; equal to running XOR -> DONE, else -> ERROR. The CHK byte is not folded into XOR.
- DONE: done=1, cpu_rst=0. Outputs hold until start or rst.
- ERROR: error=1, cpu_rst=1. Partial writes already issued are not undone.
- start pulse:
  - in DONE/ERROR: -> LEN_LO; clears done, error, words_loaded, XOR, byte index; cpu_rst returns to 1 that same cycle.
  - in any other state: ignored.
- Full depth: N = 2**ADDR_W is legal. The last address is 2**ADDR_W-1, and words_loaded reaches 2**ADDR_W with no wrap.
- rst asserted mid-load: immediate abort to reset values; no further imem_we.
- Simultaneous start and in_valid in DONE: start takes effect; the byte is not consumed (in_ready=0 that cycle).

Test Plan:
- Basic load: bytes 02 00 | 78 56 34 12 | EF BE AD DE | CHK=0x02^0x00^0x78^0x56^0x34^0x12^0xEF^0xBE^0xAD^0xDE, in_valid held high -> imem_we at addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF, each 1 cycle after the 4th byte; done=1, cpu_rst=0, words_loaded=2.
- Bad checksum: same frame with CHK inverted -> both writes still occur; error=1, done=0, cpu_rst stays 1; in_ready=0.
- Length overflow (ADDR_W=8): bytes 01 01 (N=257) -> ERROR right after second byte; no imem_we ever asserted.
- Zero length: 00 00 00 -> no writes; done=1, words_loaded=0.
- Gapped handshake: basic frame with in_valid toggled randomly at about 50% -> identical write sequence and final state as the basic load.
- Re-arm and reset: after DONE, pulse start (cpu_rst=1 the same cycle), load a 1-word frame 0xCAFEF00D -> addr 0 written. Then assert rst mid-DATA -> all outputs return to reset values asynchronously.
